// File: rtl/wb_ram_pkg.sv
// Shared definitions for the Wishbone RAM front-end and its helpers.
//   state_t  : 2-bit controller state encoding (IDLE, RD, RMW, DONE)
//   SEL_FULL : byte-select pattern of a whole-word access
//   idxWidth : word-index width for a RAM of a given depth
package wb_ram_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_RMW  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] SEL_FULL = 4'hF;

  // Never returns 0, so a single-word RAM still gets a 1-bit index.
  function automatic int idxWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/wb_ram_rmw_ctrl_if.sv
// Wishbone classic bus bundle between a bus master and the RAM front-end.
// Handshake: the master holds cyc and stb high together with adr/dat/sel/we
// until the slave returns a single-cycle ack; the master then either drops
// cyc/stb or presents its next request. For reads, dat_o is valid in the
// ack cycle. A master that drops cyc before the ack abandons the response.
//   master : drives adr/dat_i/sel/we/cyc/stb, receives dat_o/ack
//   slave  : receives adr/dat_i/sel/we/cyc/stb, drives dat_o/ack
interface wb_ram_rmw_ctrl_if #(
  parameter int aw = 32
);
  logic [aw-1:0] wb_adr_i;
  logic [31:0]   wb_dat_i;
  logic [3:0]    wb_sel_i;
  logic          wb_we_i;
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_ram_byte_merge.sv
// Combinational 4-lane byte merge: each byte lane takes the new data when its
// select bit is set, otherwise keeps the old data.
//   sel     in  4   per-lane select (1 = take newData)
//   newData in  32  incoming write data
//   oldData in  32  data currently stored
//   merged  out 32  lane-wise merge result
module wb_ram_byte_merge (
  input  logic [3:0]  sel,
  input  logic [31:0] newData,
  input  logic [31:0] oldData,
  output logic [31:0] merged
);

  always_comb begin
    merged = oldData;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) merged[8*i +: 8] = newData[8*i +: 8];
    end
  end

endmodule

// File: rtl/wb_ram_rmw_ctrl.sv
// Wishbone classic slave in front of the ECC word RAM. Full-word writes go
// straight to the RAM; byte-select writes become read-modify-write so the
// RAM only ever sees whole-word writes; reads return registered data.
//   clk, rst   clock, asynchronous active-high reset
//   bus        Wishbone slave port (adr/dat/sel/we/cyc/stb in, dat/ack out)
//   mem_we     RAM write enables, only 4'h0 or 4'hF
//   mem_din    RAM write data
//   mem_waddr  RAM write word address
//   mem_raddr  RAM read word address
//   mem_dout   RAM read data, valid the cycle after mem_raddr is sampled
//   rmw_count  saturating count of completed RMW writes
//   dbgState   current controller state
module wb_ram_rmw_ctrl
  import wb_ram_pkg::*;
#(
  parameter int depth = 256,
  parameter int aw    = 32,
  parameter int cw    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  wb_ram_rmw_ctrl_if.slave            bus,
  output logic [3:0]                  mem_we,
  output logic [31:0]                 mem_din,
  output logic [idxWidth(depth)-1:0]  mem_waddr,
  output logic [idxWidth(depth)-1:0]  mem_raddr,
  input  logic [31:0]                 mem_dout,
  output logic [cw-1:0]               rmw_count,
  output state_t                      dbgState
);

  localparam int iw = idxWidth(depth);

  state_t        state, stateNext;
  logic [iw-1:0] adrQ;
  logic [31:0]   datQ;
  logic [3:0]    selQ;
  logic [31:0]   datO;
  logic [cw-1:0] countQ;
  logic [3:0]    memWe;
  logic          ack;
  logic [31:0]   merged;
  logic [aw-1:0] adrFull;
  logic [iw-1:0] reqIdx;
  logic          req;

  // Upper address bits are deliberately ignored, so addresses alias.
  assign adrFull = bus.wb_adr_i;
  assign reqIdx  = adrFull[iw+1:2];
  assign req     = bus.wb_cyc_i & bus.wb_stb_i;

  wb_ram_byte_merge u_merge (
    .sel     (selQ),
    .newData (datQ),
    .oldData (mem_dout),
    .merged  (merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= stateNext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adrQ <= '0;
      datQ <= '0;
      selQ <= '0;
    end else if (state == S_IDLE && req) begin
      adrQ <= reqIdx;
      datQ <= bus.wb_dat_i;
      selQ <= bus.wb_sel_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 datO <= '0;
    else if (state == S_RD)  datO <= mem_dout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    countQ <= '0;
    else if (state == S_RMW && countQ != '1)    countQ <= countQ + 1'b1;
  end

  always_comb begin
    stateNext = state;
    memWe     = 4'h0;
    mem_din   = datQ;
    mem_waddr = adrQ;
    mem_raddr = adrQ;
    ack       = 1'b0;
    case (state)
      S_IDLE: begin
        // Read address follows the bus every IDLE cycle so that the old word
        // is already on mem_dout in the RD or RMW cycle.
        mem_raddr = reqIdx;
        mem_waddr = reqIdx;
        mem_din   = bus.wb_dat_i;
        if (req) begin
          if (bus.wb_we_i) begin
            if (bus.wb_sel_i == SEL_FULL) begin
              memWe     = SEL_FULL;
              stateNext = S_DONE;
            end else if (bus.wb_sel_i == 4'h0) begin
              stateNext = S_DONE;
            end else begin
              stateNext = S_RMW;
            end
          end else begin
            stateNext = S_RD;
          end
        end
      end
      S_RD: stateNext = S_DONE;
      S_RMW: begin
        // Completes even if the master has dropped cyc: the write is atomic.
        memWe     = SEL_FULL;
        mem_din   = merged;
        stateNext = S_DONE;
      end
      S_DONE: begin
        ack       = bus.wb_cyc_i;
        stateNext = S_IDLE;
      end
      default: stateNext = S_IDLE;
    endcase
  end

  // Gate with reset so a write in flight is cancelled the instant rst rises.
  assign mem_we       = rst ? 4'h0 : memWe;
  assign bus.wb_ack_o = ack;
  assign bus.wb_dat_o = datO;
  assign rmw_count    = countQ;
  assign dbgState     = state;

endmodule

// File: tb/tb_wb_ram_rmw_ctrl.sv
module tb_wb_ram_rmw_ctrl;
  import wb_ram_pkg::*;

  localparam int DEPTH = 256;
  localparam int AW    = 32;
  localparam int CW    = 2;
  localparam int IW    = 8;

  logic          clk;
  logic          rst;
  logic [3:0]    mem_we;
  logic [31:0]   mem_din;
  logic [31:0]   mem_dout;
  logic [IW-1:0] mem_waddr;
  logic [IW-1:0] mem_raddr;
  logic [CW-1:0] rmw_count;
  state_t        dbgState;

  wb_ram_rmw_ctrl_if #(.aw(AW)) bus ();

  wb_ram_rmw_ctrl #(.depth(DEPTH), .aw(AW), .cw(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .mem_we    (mem_we),
    .mem_din   (mem_din),
    .mem_waddr (mem_waddr),
    .mem_raddr (mem_raddr),
    .mem_dout  (mem_dout),
    .rmw_count (rmw_count),
    .dbgState  (dbgState)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM model ----------------
  logic [31:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_we == 4'hF) ram[mem_waddr] <= mem_din;
    mem_dout <= ram[mem_raddr];
  end

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];   // {is_read, read_data} per expected ack
  logic [39:0] wexp_q[$];  // {word_index, data} per expected RAM write
  int checks   = 0;
  int failures = 0;
  logic [32:0] mon_e;
  logic [39:0] mon_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.wb_ack_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ack actual=1 required=0");
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e[32]) check("read_data", bus.wb_dat_o, mon_e[31:0]);
      end
    end
    if (mem_we != 4'h0) begin
      check("mem_we_full", {28'h0, mem_we}, 32'hF);
      checks++;
      if (wexp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual=%h@%0d required=none", mem_din, mem_waddr);
      end else begin
        mon_w = wexp_q.pop_front();
        check("write_addr", {24'h0, mem_waddr}, {24'h0, mon_w[39:32]});
        check("write_data", mem_din, mon_w[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the next IDLE cycle.
  task automatic wb_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int exp_lat, input string name);
    int lat;
    bus.wb_adr_i = adr;
    bus.wb_dat_i = dat;
    bus.wb_sel_i = sel;
    bus.wb_we_i  = we;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    #1;
    check({name, "_raddr"}, {24'h0, mem_raddr}, {24'h0, adr[9:2]});
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!bus.wb_ack_o && lat < 8);
    check({name, "_latency"}, lat, exp_lat);
    @(posedge clk);
    #1;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] idx, input logic [31:0] dat, input logic [3:0] sel,
                          input logic [31:0] merged, input string name);
    int lat;
    exp_q.push_back({1'b0, 32'h0});
    if (sel == 4'hF) begin
      wexp_q.push_back({idx, dat});
      lat = 1;
    end else if (sel == 4'h0) begin
      lat = 1;
    end else begin
      wexp_q.push_back({idx, merged});
      lat = 2;
    end
    wb_txn(1'b1, {22'h0, idx, 2'b00}, dat, sel, lat, name);
  endtask

  task automatic do_read(input logic [31:0] adr, input logic [31:0] exp, input string name);
    exp_q.push_back({1'b1, exp});
    wb_txn(1'b0, adr, 32'h0, 4'hF, 2, name);
  endtask

  // ---------------- stimulus ----------------
  int sat_exp [5] = '{1, 2, 3, 3, 3};

  initial begin
    rst = 1'b0;
    bus.wb_adr_i = '0;
    bus.wb_dat_i = '0;
    bus.wb_sel_i = '0;
    bus.wb_we_i  = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", {31'h0, bus.wb_ack_o}, 32'h0);
    check("rst_dat_o", bus.wb_dat_o, 32'h0);
    check("rst_mem_we", {28'h0, mem_we}, 32'h0);
    check("rst_state", {30'h0, dbgState}, {30'h0, S_IDLE});
    check("rst_count", {30'h0, rmw_count}, 32'h0);
    rst = 1'b0;

    // Full write then back-to-back read of the same word
    do_write(8'd5, 32'hDEADBEEF, 4'hF, 32'h0, "full_wr5");
    do_read(32'h14, 32'hDEADBEEF, "rd5");
    check("count_after_full", {30'h0, rmw_count}, 32'h0);

    // Partial write: 0x11223344 merged with 0xAABBCCDD under sel 0101
    do_write(8'd7, 32'h11223344, 4'hF, 32'h0, "preload7");
    do_write(8'd7, 32'hAABBCCDD, 4'b0101, 32'h11BB33DD, "part_wr7");
    check("count_after_part", {30'h0, rmw_count}, 32'h1);
    do_read(32'h1C, 32'h11BB33DD, "rd7");

    // Null write leaves memory untouched
    do_write(8'd3, 32'h55555555, 4'hF, 32'h0, "preload3");
    do_write(8'd3, 32'hFFFFFFFF, 4'h0, 32'h0, "null_wr3");
    do_read(32'h0C, 32'h55555555, "rd3");

    // Reset asserted during the RMW cycle: no write, no ack, counter cleared
    bus.wb_adr_i = 32'h1C;
    bus.wb_dat_i = 32'h00000000;
    bus.wb_sel_i = 4'b0011;
    bus.wb_we_i  = 1'b1;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst_state", {30'h0, dbgState}, {30'h0, S_RMW});
    rst = 1'b1;
    #1;
    check("midrst_mem_we", {28'h0, mem_we}, 32'h0);
    check("midrst_ack", {31'h0, bus.wb_ack_o}, 32'h0);
    check("midrst_state", {30'h0, dbgState}, {30'h0, S_IDLE});
    check("midrst_count", {30'h0, rmw_count}, 32'h0);
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_read(32'h1C, 32'h11BB33DD, "rd7_after_rst");

    // cyc dropped during RMW: write still lands, ack suppressed
    do_write(8'd9, 32'h00000000, 4'hF, 32'h0, "preload9");
    wexp_q.push_back({8'd9, 32'hFF000000});
    bus.wb_adr_i = 32'h24;
    bus.wb_dat_i = 32'hFF000000;
    bus.wb_sel_i = 4'b1000;
    bus.wb_we_i  = 1'b1;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    @(posedge clk);
    #1;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_state", {30'h0, dbgState}, {30'h0, S_IDLE});
    check("abort_count", {30'h0, rmw_count}, 32'h1);
    // Upper address bits alias onto word 9
    do_read(32'h0001_0024, 32'hFF000000, "rd9_alias");

    // Saturation with a 2-bit counter
    rst = 1'b1;
    #2;
    rst = 1'b0;
    check("sat_start_count", {30'h0, rmw_count}, 32'h0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      do_write(8'd7, 32'(i + 1), 4'b0001, {24'h11BB33, 8'(i + 1)}, "sat_wr");
      check("sat_count", {30'h0, rmw_count}, 32'(sat_exp[i]));
    end
    do_read(32'h1C, 32'h11BB3305, "rd7_final");

    repeat (3) @(posedge clk);
    #1;
    check("ack_queue_drained", exp_q.size(), 32'h0);
    check("write_queue_drained", wexp_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_ram_rmw_ctrl.md
Name: wb_ram_rmw_ctrl

Overview:
Wishbone classic slave front-end that sits directly upstream of the ECC word RAM and drives its we/din/waddr/raddr ports.
- Partial (byte-select) writes become a read-modify-write sequence, so every RAM write is a full 4'hF word write and the stored ECC signature always stays valid.
- Full-word writes and reads pass through with fixed latency.
- A saturating counter reports how many RMW sequences have been performed.

Parameters:
- depth, 256, RAM words; must match the downstream RAM.
- aw, 32, Wishbone byte-address width.
- cw, 16, width of rmw_count.

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- wb_adr_i  in  aw  byte address; word index = wb_adr_i[$clog2(depth)+1:2]; upper bits ignored
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte selects
- wb_we_i  in  1  write strobe
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_dat_o  out  32  read data (registered)
- wb_ack_o  out  1  one-cycle acknowledge
- mem_we  out  4  RAM write enables; only 4'h0 or 4'hF are ever driven
- mem_din  out  32  RAM write data
- mem_waddr  out  $clog2(depth)  RAM write word address
- mem_raddr  out  $clog2(depth)  RAM read word address
- mem_dout  in  32  RAM read data; valid the cycle after mem_raddr is sampled
- rmw_count  out  cw  number of completed RMW writes; saturates at all-ones

Behaviour:
Reset (async, rst=1): state=IDLE; wb_ack_o=0; wb_dat_o=0; mem_we=0 immediately; request latches=0; rmw_count=0.

States: IDLE, RD, RMW, DONE. Encoding is 2 bits.

IDLE
- mem_raddr = word index of wb_adr_i, combinational, every cycle.
- A request is cyc&stb. On a request, latch adr, dat, sel and we.
- Full write (we=1, sel=4'hF): mem_we=4'hF, mem_waddr=index, mem_din=wb_dat_i in this same cycle. Next state DONE.
- Partial write (we=1, sel not 0 and not F): no write this cycle. Next state RMW.
- Null write (we=1, sel=0): no memory access. Next state DONE.
- Read (we=0, any sel): next state RD.

RD
- wb_dat_o <= mem_dout.
- Next state DONE.

RMW
- merged byte i = sel_q[i] ? dat_q[8i+7:8i] : mem_dout[8i+7:8i].
- mem_we=4'hF, mem_waddr=latched index, mem_din=merged.
- rmw_count increments unless already saturated.
- Next state DONE.

DONE
- wb_ack_o=1 for exactly this cycle.
- cyc/stb are ignored.
- Next state IDLE.

Latency from request sampled in IDLE at cycle T:
- Full or null write: ack at T+1.
- Read: ack at T+2, with wb_dat_o valid at the ack cycle.
- Partial write: ack at T+2.

Back-to-back: a new request is accepted in the IDLE cycle immediately after DONE, giving a minimum period of 2 or 3 cycles.

Boundary conditions:
- cyc drop mid-transaction (cyc falls while in RD or RMW): the sequence still completes, including the RMW write (atomic). DONE is entered but wb_ack_o is suppressed when cyc_i=0 in DONE.
- mem_we is 0 in every state except the full-write IDLE cycle and RMW.
- Read-after-write to the same address in the next transaction returns the new data; the write completes before the next IDLE read issue.
- wb_err_o and retry are not supported.
- Address bits above the index are not range-checked and alias.

Decomposition:
Shared package/include wb_ram_pkg holds:
- state localparams S_IDLE=0, S_RD=1, S_RMW=2, S_DONE=3
- SEL_FULL=4'hF
- an index-width function (clog2 wrapper)

One sub-module, wb_ram_byte_merge: combinational 4-lane mux (sel, new, old -> merged). It is reused later by the scrubber.

Test Plan:
- Reset mid-RMW: assert rst during the RMW cycle -> mem_we=0 at once, wb_ack_o=0, state IDLE, rmw_count=0; no RAM write occurs.
- Full write then read: write 0xDEADBEEF sel=F to word 5, then read word 5 -> ack at T+1 for the write; mem_we=F for one cycle; read ack at T+2 returning 0xDEADBEEF; rmw_count unchanged.
- Partial write: word 7 holds 0x11223344; write 0xAABBCCDD sel=4'b0101 -> mem_raddr=7 at T; at T+1 mem_we=F with mem_din=0x11BB33DD; ack at T+2; rmw_count +1; readback 0x11BB33DD.
- Null write: sel=0 write to word 3 holding 0x55555555 -> ack at T+1, mem_we never nonzero, readback 0x55555555.
- cyc abort: drop cyc during RMW on a sel=4'b1000 write of 0xFF000000 over 0 -> no ack; word holds 0xFF000000; next request accepted normally.
- Saturation: with cw=2, do five partial writes -> rmw_count sequence 1,2,3,3,3.
